// File: rtl/clock_logic_pkg.sv
// Shared defaults, legal parameter ranges and sizing helper for the
// clock-domain-crossing synchronizer / glitch filter block.
package clock_logic_pkg;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 4;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILTER_MIN = 1;
  localparam int FILTER_MAX = 255;

  // Counter must be able to hold FILTER_CYCLES-1 for every legal setting.
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/clock_logic_glitch_filter.sv
// One channel: persistence counter, filtered output register and
// edge pulse generation from an already-synchronized level.
module clock_logic_glitch_filter
  import clock_logic_pkg::*;
#(
  parameter int   FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter logic RESET_BIT     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_sync,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_load
);

  localparam int               CNT_W = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FILTER_CYCLES - 1);

  logic             r_data;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_load;

  always_comb begin
    w_diff = (i_sync != r_data);
    w_load = w_diff && (r_cnt == LAST);
  end

  // Pulses are registered alongside r_data so they line up with the new level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= RESET_BIT;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_load & i_sync;
      r_fall <= w_load & ~i_sync;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_load) begin
        r_data <= i_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_data = r_data;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_load = w_load;

endmodule

// File: rtl/clock_logic_cross_sync_filt.sv
// Multi-channel level synchronizer with per-channel glitch filter and
// registered rise/fall/any-change pulses.
module clock_logic_cross_sync_filt
  import clock_logic_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               STAGES        = SYNC_STAGES_DEF,
  parameter int               FIRST_NEG     = 1,
  parameter int               FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "clock_logic_cross_sync_filt: WIDTH out of range 1..32");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "clock_logic_cross_sync_filt: STAGES out of range 2..4");
  end
  if (FILTER_CYCLES < FILTER_MIN || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
    $fatal(1, "clock_logic_cross_sync_filt: FILTER_CYCLES out of range 1..255");
  end
  if (FIRST_NEG != 0 && FIRST_NEG != 1) begin : g_bad_first_neg
    $fatal(1, "clock_logic_cross_sync_filt: FIRST_NEG must be 0 or 1");
  end

  (* async_reg = "true", keep = "true" *) logic [WIDTH-1:0] r_sync_first;
  (* async_reg = "true", keep = "true" *) logic [WIDTH-1:0] r_sync_tail [STAGES-1];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_load;
  logic             r_any_change;

  // The falling-edge first stage also resets synchronously, on its own edge.
  if (FIRST_NEG != 0) begin : g_first_neg
    always_ff @(negedge clock) begin
      if (reset) r_sync_first <= RESET_VALUE;
      else       r_sync_first <= data_in;
    end
  end else begin : g_first_pos
    always_ff @(posedge clock) begin
      if (reset) r_sync_first <= RESET_VALUE;
      else       r_sync_first <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES - 1; i++) r_sync_tail[i] <= RESET_VALUE;
    end else begin
      r_sync_tail[0] <= r_sync_first;
      for (int i = 1; i < STAGES - 1; i++) r_sync_tail[i] <= r_sync_tail[i-1];
    end
  end

  assign w_sync = r_sync_tail[STAGES-2];

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    clock_logic_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VALUE[g])
    ) u_filt (
      .clock  (clock),
      .reset  (reset),
      .i_sync (w_sync[g]),
      .o_data (data_out[g]),
      .o_rise (rise_pulse[g]),
      .o_fall (fall_pulse[g]),
      .o_load (w_load[g])
    );
  end

  // Registered from the same load strobes, so it coincides with the pulses.
  always_ff @(posedge clock) begin
    if (reset) r_any_change <= 1'b0;
    else       r_any_change <= |w_load;
  end

  assign any_change = r_any_change;

endmodule

// File: tb/tb_clock_logic_cross_sync_filt.sv
// Directed bench: rising-edge 4-channel instance plus falling-edge-first
// 32- and 1-channel instances checked against a reference model.
module tb_clock_logic_cross_sync_filt;

  logic        clk;
  logic        rst_a, rst_b;
  logic [3:0]  din_a, out_a, rise_a, fall_a;
  logic        any_a;
  logic [31:0] din_b, out_b, rise_b, fall_b;
  logic        any_b;
  logic [0:0]  din_c, out_c, rise_c, fall_c;
  logic        any_c;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state for FIRST_NEG=1, STAGES=2, FILTER_CYCLES=1.
  logic [31:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic        m_any, m_any_c;

  assign din_c = din_b[0:0];

  clock_logic_cross_sync_filt #(
    .WIDTH(4), .STAGES(2), .FIRST_NEG(0), .FILTER_CYCLES(4), .RESET_VALUE(4'hF)
  ) u_dut_a (
    .clock(clk), .reset(rst_a), .data_in(din_a), .data_out(out_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
  );

  clock_logic_cross_sync_filt #(
    .WIDTH(32), .STAGES(2), .FIRST_NEG(1), .FILTER_CYCLES(1), .RESET_VALUE(32'hFFFF_FFFF)
  ) u_dut_b (
    .clock(clk), .reset(rst_b), .data_in(din_b), .data_out(out_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
  );

  clock_logic_cross_sync_filt #(
    .WIDTH(1), .STAGES(2), .FIRST_NEG(1), .FILTER_CYCLES(1), .RESET_VALUE(1'b1)
  ) u_dut_c (
    .clock(clk), .reset(rst_b), .data_in(din_c), .data_out(out_c),
    .rise_pulse(rise_c), .fall_pulse(fall_c), .any_change(any_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: with a one-cycle filter the output simply follows s
  always @(negedge clk) begin
    if (rst_b) m_s1 <= '1;
    else       m_s1 <= din_b;
  end

  always @(posedge clk) begin
    logic [31:0] r_n, f_n;
    if (rst_b) begin
      m_s2 <= '1; m_out <= '1; m_rise <= '0; m_fall <= '0;
      m_any <= 1'b0; m_any_c <= 1'b0;
    end else begin
      r_n = m_s2 & ~m_out;
      f_n = ~m_s2 & m_out;
      m_s2    <= m_s1;
      m_out   <= m_s2;
      m_rise  <= r_n;
      m_fall  <= f_n;
      m_any   <= |(r_n | f_n);
      m_any_c <= r_n[0] | f_n[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e_out, e_rise, e_fall;
    rst_a = 1'b1; rst_b = 1'b1;
    din_a = 4'h0; din_b = '1;
    step(3);
    chk("rst_out_a",  {28'h0, out_a},  32'hF);
    chk("rst_rise_a", {28'h0, rise_a}, 32'h0);
    chk("rst_fall_a", {28'h0, fall_a}, 32'h0);
    chk("rst_any_a",  {31'h0, any_a},  32'h0);
    chk("rst_out_b",  out_b, 32'hFFFF_FFFF);
    chk("rst_out_c",  {31'h0, out_c},  32'h1);

    // release; data_in=0 was held through reset, so all channels fall later
    rst_a = 1'b0; rst_b = 1'b0;
    step(1);
    chk("post_rst_fall_a", {28'h0, fall_a}, 32'h0);
    chk("post_rst_any_a",  {31'h0, any_a},  32'h0);
    chk("post_rst_any_b",  {31'h0, any_b},  32'h0);
    step(4);
    chk("rst_lat_hold_a",  {28'h0, out_a},  32'hF);
    step(1);
    chk("rst_lat_out_a",   {28'h0, out_a},  32'h0);
    chk("rst_lat_fall_a",  {28'h0, fall_a}, 32'hF);
    chk("rst_lat_any_a",   {31'h0, any_a},  32'h1);
    step(1);
    chk("rst_lat_fall_end", {28'h0, fall_a}, 32'h0);

    // latency: change before edge E, output at E+5
    din_a = 4'h1;
    step(5);
    chk("lat_early_out", {28'h0, out_a},  32'h0);
    chk("lat_early_rise", {28'h0, rise_a}, 32'h0);
    step(1);
    chk("lat_out",  {28'h0, out_a},  32'h1);
    chk("lat_rise", {28'h0, rise_a}, 32'h1);
    chk("lat_any",  {31'h0, any_a},  32'h1);
    step(1);
    chk("lat_rise_end", {28'h0, rise_a}, 32'h0);
    chk("lat_any_end",  {31'h0, any_a},  32'h0);

    // glitch: ch1 high for 3 clocks is rejected
    din_a[1] = 1'b1;
    step(3);
    din_a[1] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step(1);
      chk("glitch_out",  {28'h0, out_a},  32'h1);
      chk("glitch_rise", {28'h0, rise_a}, 32'h0);
      chk("glitch_fall", {28'h0, fall_a}, 32'h0);
    end

    // ch1 high for 4 clocks passes: rise at n=6, fall at n=10
    din_a[1] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step(1);
      if (n == 4) din_a[1] = 1'b0;
      e_out  = (n >= 6 && n < 10) ? 4'h3 : 4'h1;
      e_rise = (n == 6)  ? 4'h2 : 4'h0;
      e_fall = (n == 10) ? 4'h2 : 4'h0;
      chk("pass4_out",  {28'h0, out_a},  {28'h0, e_out});
      chk("pass4_rise", {28'h0, rise_a}, {28'h0, e_rise});
      chk("pass4_fall", {28'h0, fall_a}, {28'h0, e_fall});
    end

    // simultaneous fall on ch0 and ch3
    din_a = 4'b1001;
    step(8);
    chk("simul_setup", {28'h0, out_a}, 32'h9);
    din_a = 4'b0000;
    step(5);
    chk("simul_early_fall", {28'h0, fall_a}, 32'h0);
    step(1);
    chk("simul_fall", {28'h0, fall_a}, 32'h9);
    chk("simul_rise", {28'h0, rise_a}, 32'h0);
    chk("simul_any",  {31'h0, any_a},  32'h1);
    chk("simul_out",  {28'h0, out_a},  32'h0);

    // reset while ch2 count is at 2
    din_a = 4'b0100;
    step(4);
    rst_a = 1'b1;
    step(1);
    chk("midrst_out",  {28'h0, out_a},  32'hF);
    chk("midrst_rise", {28'h0, rise_a}, 32'h0);
    chk("midrst_any",  {31'h0, any_a},  32'h0);
    rst_a = 1'b0;
    din_a = 4'hF;
    for (int n = 0; n < 10; n++) begin
      step(1);
      chk("midrst_hold_out",  {28'h0, out_a},  32'hF);
      chk("midrst_hold_rise", {28'h0, rise_a}, 32'h0);
      chk("midrst_hold_fall", {28'h0, fall_a}, 32'h0);
      chk("midrst_hold_any",  {31'h0, any_a},  32'h0);
    end

    // falling-edge first stage: change before F, output at F+1.5 cycles
    #1;
    din_b = 32'h0000_FFFE;
    step(1);
    chk("neg_early_out_b", out_b, 32'hFFFF_FFFF);
    chk("neg_early_out_c", {31'h0, out_c}, 32'h1);
    step(1);
    chk("neg_out_b",  out_b,  32'h0000_FFFE);
    chk("neg_fall_b", fall_b, 32'hFFFF_0001);
    chk("neg_any_b",  {31'h0, any_b}, 32'h1);
    chk("neg_out_c",  {31'h0, out_c},  32'h0);
    chk("neg_fall_c", {31'h0, fall_c}, 32'h1);

    // random async data vs. model, driven at varying offsets
    for (int n = 0; n < 300; n++) begin
      step(1);
      chk("rnd_out_b",  out_b,  m_out);
      chk("rnd_rise_b", rise_b, m_rise);
      chk("rnd_fall_b", fall_b, m_fall);
      chk("rnd_any_b",  {31'h0, any_b},  {31'h0, m_any});
      chk("rnd_out_c",  {31'h0, out_c},  {31'h0, m_out[0]});
      chk("rnd_rise_c", {31'h0, rise_c}, {31'h0, m_rise[0]});
      chk("rnd_fall_c", {31'h0, fall_c}, {31'h0, m_fall[0]});
      chk("rnd_any_c",  {31'h0, any_c},  {31'h0, m_any_c});
      if ($urandom_range(0, 1) == 1) #1;
      else                           #6;
      if ($urandom_range(0, 3) != 0) din_b = $urandom;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_logic_cross_sync_filt.md
CLOCK_LOGIC_CROSS_SYNC_FILT -- requirements
Module: clock_logic_cross_sync_filt

Interface
REQ-001 Parameter WIDTH, default 4: number of independent single-bit channels; legal range 1..32.
REQ-002 Parameter STAGES, default 2: synchronizer flops per channel; legal range 2..4.
REQ-003 Parameter FIRST_NEG, default 1: 1 = first synchronizer stage clocked on falling edge of clock, 0 = all stages on rising edge.
REQ-004 Parameter FILTER_CYCLES, default 4: consecutive cycles a new synchronized level must persist before data_out follows; legal range 1..255.
REQ-005 Parameter RESET_VALUE, default all-ones, WIDTH bits: level loaded into every synchronizer stage and data_out on reset.
REQ-006 clock  input  1  sole clock; all state on rising edge except first stage when FIRST_NEG=1.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_in  input  WIDTH  asynchronous level inputs, one per channel.
REQ-009 data_out  output  WIDTH  synchronized, glitch-filtered levels, registered.
REQ-010 rise_pulse  output  WIDTH  one-cycle pulse per channel on data_out 0->1, registered.
REQ-011 fall_pulse  output  WIDTH  one-cycle pulse per channel on data_out 1->0, registered.
REQ-012 any_change  output  1  registered OR of rise_pulse|fall_pulse, same cycle as the pulses.

Function
REQ-013 Each channel SHALL pass data_in through a STAGES-deep flop chain; sync value s = last stage output.
REQ-014 Each channel SHALL hold a counter cnt of width clog2(FILTER_CYCLES+1), cleared whenever s equals data_out.
REQ-015 While s differs from data_out and cnt < FILTER_CYCLES-1, cnt SHALL increment by 1 per rising edge.
REQ-016 When s differs from data_out and cnt == FILTER_CYCLES-1, the next rising edge SHALL load data_out<=s and clear cnt.
REQ-017 If s returns to data_out before REQ-016 fires, cnt SHALL clear and data_out SHALL not change, with no pulse.
REQ-018 rise_pulse/fall_pulse SHALL be high exactly in the first cycle data_out holds its new value, low otherwise.
REQ-019 Latency, FIRST_NEG=0: data_out changes on rising edge number STAGES+FILTER_CYCLES-1 after the rising edge that first captures a stable new data_in.
REQ-020 Latency, FIRST_NEG=1: data_out changes STAGES+FILTER_CYCLES-1.5 cycles after the falling edge that first captures a stable new data_in.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulse in the same cycle.
REQ-022 Illegal parameter values SHALL stop elaboration with a fatal message.

Reset
REQ-023 While reset is high at a clock edge, every synchronizer stage (including a falling-edge first stage) and data_out SHALL load RESET_VALUE, cnt SHALL load 0.
REQ-024 rise_pulse, fall_pulse and any_change SHALL be 0 during reset and in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-count SHALL discard the pending transition; no pulse SHALL result from reset itself.

Structure
REQ-026 Package clock_logic_pkg SHALL hold the default constants (SYNC_STAGES_DEF=2, FILTER_CYCLES_DEF=4) and parameter range limits.
REQ-027 Sub-module clock_logic_glitch_filter SHALL implement one channel's counter, data_out register and pulse generation; the top instantiates it WIDTH times via generate.
REQ-028 Synchronizer chains SHALL be in the top level, flops carrying the synthesis async_reg/keep attribute; the existing set-type cell SHALL not be reused, as its reset style differs.

Verification
REQ-029 Reset: WIDTH=4, RESET_VALUE=4'hF, data_in=4'h0 held through reset -> data_out=4'hF, all pulses 0, first pulse only after the filter latency.
REQ-030 Latency: FIRST_NEG=0, STAGES=2, FILTER_CYCLES=4, ch0 0->1 before rising edge E -> data_out[0]=1 and rise_pulse[0]=1 for one cycle at E+5.
REQ-031 Glitch reject: FILTER_CYCLES=4, ch1 high for 3 clocks then low -> no change on data_out[1], no pulse; high for 4 clocks -> rise then fall with one pulse each.
REQ-032 Simultaneous: channels 0 and 3 fall at the same instant -> fall_pulse=4'b1001 and any_change=1 in one cycle.
REQ-033 Reset mid-count: assert reset while cnt=2 on ch2 -> cnt=0, data_out=RESET_VALUE, no pulse after release.
REQ-034 FIRST_NEG=1, FILTER_CYCLES=1, STAGES=2: change before falling edge F -> data_out updates at F+1.5 cycles; randomized async data_in vs. reference model across WIDTH=1/32.
